// File: rtl/morse_pkg.sv
// Shared types and constants for the A-H Morse letter transmitter:
// FSM encoding, counter widths, unit counts and the letter code ROM.
package morse_pkg;

  localparam int unsigned PRESC_W = 25;
  localparam int unsigned UNIT_W  = 2;
  localparam int unsigned SYM_W   = 3;
  localparam int unsigned PAT_W   = 4;
  localparam int unsigned LTR_W   = 3;

  localparam int unsigned DOT_UNITS  = 1;
  localparam int unsigned DASH_UNITS = 3;
  localparam int unsigned GAP_UNITS  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

  typedef struct packed {
    logic [SYM_W-1:0] len;
    logic [PAT_W-1:0] pat;
  } code_t;

  // Pattern is left-aligned, 1 = dash, first symbol in the MSB.
  function automatic code_t code_lookup(input logic [LTR_W-1:0] idx);
    code_t c;
    case (idx)
      3'd0:    c = '{len: 3'd2, pat: 4'b0100};
      3'd1:    c = '{len: 3'd4, pat: 4'b1000};
      3'd2:    c = '{len: 3'd4, pat: 4'b1010};
      3'd3:    c = '{len: 3'd3, pat: 4'b1000};
      3'd4:    c = '{len: 3'd1, pat: 4'b0000};
      3'd5:    c = '{len: 3'd4, pat: 4'b0010};
      3'd6:    c = '{len: 3'd3, pat: 4'b1100};
      default: c = '{len: 3'd4, pat: 4'b0000};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// Unit-rate prescaler: counts 0..TICK_DIV-1 and flags the last count of
// each Morse unit; a synchronous clear restarts the unit.
module morse_unit_tick
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] r_cnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PRESC_W'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/morse_letter_tx.sv
// Morse transmitter for letters A-H: latches a letter on start and plays
// its dot/dash sequence on morse_out, pulsing done when the last mark ends.
module morse_letter_tx
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [LTR_W-1:0] letter,
  output logic             morse_out,
  output logic             busy,
  output logic             done
);

  state_t            r_state, w_state_nxt;
  logic [PAT_W-1:0]  r_pat, w_pat_nxt;
  logic [SYM_W-1:0]  r_sym, w_sym_nxt;
  logic [UNIT_W-1:0] r_unit, w_unit_nxt, w_unit_last;
  logic              r_morse, r_busy, r_done;
  logic              w_morse_nxt, w_busy_nxt, w_done_nxt;
  logic              w_clear, w_tick;
  code_t             w_code;

  assign w_code = code_lookup(letter);

  morse_unit_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .Clock (Clock),
    .Reset (Reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // Last unit index of the current phase; SPACE always lasts a gap.
  always_comb begin
    w_unit_last = UNIT_W'(DOT_UNITS - 1);
    if (r_state == ST_SPACE) begin
      w_unit_last = UNIT_W'(GAP_UNITS - 1);
    end else if (r_pat[PAT_W-1]) begin
      w_unit_last = UNIT_W'(DASH_UNITS - 1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_sym_nxt   = r_sym;
    w_unit_nxt  = r_unit;
    w_clear     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clear    = 1'b1;
        w_unit_nxt = '0;
        if (start) begin
          w_state_nxt = ST_MARK;
          w_pat_nxt   = w_code.pat;
          w_sym_nxt   = w_code.len;
        end
      end
      ST_MARK: begin
        if (w_tick) begin
          if (r_unit == w_unit_last) begin
            w_clear    = 1'b1;
            w_unit_nxt = '0;
            if (r_sym > SYM_W'(1)) begin
              w_state_nxt = ST_SPACE;
              w_pat_nxt   = {r_pat[PAT_W-2:0], 1'b0};
              w_sym_nxt   = r_sym - SYM_W'(1);
            end else begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_unit_nxt = r_unit + UNIT_W'(1);
          end
        end
      end
      ST_SPACE: begin
        if (w_tick) begin
          if (r_unit == w_unit_last) begin
            w_clear     = 1'b1;
            w_unit_nxt  = '0;
            w_state_nxt = ST_MARK;
          end else begin
            w_unit_nxt = r_unit + UNIT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_morse_nxt = (w_state_nxt == ST_MARK);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_pat   <= '0;
      r_sym   <= '0;
      r_unit  <= '0;
      r_morse <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_sym   <= w_sym_nxt;
      r_unit  <= w_unit_nxt;
      r_morse <= w_morse_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign morse_out = r_morse;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_morse_letter_tx.sv
// Scoreboard bench for morse_letter_tx: per-cycle {morse_out,busy,done}
// traces are queued when a letter is requested and popped every cycle.
module tb_morse_letter_tx;

  localparam byte DASH_CH = 8'h2D;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       start4 = 1'b0, start1 = 1'b0;
  logic [2:0] letter4 = 3'd0, letter1 = 3'd0;
  logic       m4, b4, d4, m1, b1, d1;

  logic [2:0] q4[$];
  logic [2:0] q1[$];
  string      codes[8];
  int         n_total = 0;
  int         n_bad = 0;
  int         cyc = 0;

  always #5 Clock = ~Clock;

  morse_letter_tx #(.TICK_DIV(4)) u_dut4 (
    .Clock(Clock), .Reset(Reset), .start(start4), .letter(letter4),
    .morse_out(m4), .busy(b4), .done(d4)
  );

  morse_letter_tx #(.TICK_DIV(1)) u_dut1 (
    .Clock(Clock), .Reset(Reset), .start(start1), .letter(letter1),
    .morse_out(m1), .busy(b1), .done(d1)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int which, input logic [2:0] e);
    if (which == 4) q4.push_back(e);
    else            q1.push_back(e);
  endtask

  // Expected trace {morse,busy,done} from the letter's dot/dash string.
  task automatic push_letter(input int which, input int ltr, input int td);
    string s;
    int    units;
    s = codes[ltr];
    for (int i = 0; i < s.len(); i++) begin
      units = (s.getc(i) == DASH_CH) ? 3 : 1;
      repeat (units * td) push(which, 3'b110);
      if (i < s.len() - 1) repeat (td) push(which, 3'b010);
    end
    push(which, 3'b001);
  endtask

  task automatic step();
    logic [2:0] e4, e1;
    @(negedge Clock);
    cyc++;
    e4 = (q4.size() != 0) ? q4.pop_front() : 3'b000;
    e1 = (q1.size() != 0) ? q1.pop_front() : 3'b000;
    check($sformatf("d4 cyc%0d", cyc), 8'({m4, b4, d4}), 8'(e4));
    check($sformatf("d1 cyc%0d", cyc), 8'({m1, b1, d1}), 8'(e1));
  endtask

  task automatic wait_idle(input int which);
    int guard;
    guard = 0;
    while (((which == 4) ? q4.size() : q1.size()) != 0 && guard < 500) begin
      step();
      guard++;
    end
    check("drain timeout", 8'((which == 4) ? q4.size() : q1.size()), 8'd0);
  endtask

  task automatic send4(input int ltr);
    start4  = 1'b1;
    letter4 = 3'(ltr);
    push_letter(4, ltr, 4);
    step();
    start4 = 1'b0;
    wait_idle(4);
  endtask

  initial begin
    int guard;
    codes[0] = ".-";   codes[1] = "-..."; codes[2] = "-.-."; codes[3] = "-..";
    codes[4] = ".";    codes[5] = "..-."; codes[6] = "--.";  codes[7] = "....";

    repeat (2) @(negedge Clock);
    check("rst morse4", 8'(m4), 8'd0);
    check("rst busy4",  8'(b4), 8'd0);
    check("rst done4",  8'(d4), 8'd0);
    check("rst outs1",  8'({m1, b1, d1}), 8'd0);
    Reset = 1'b0;
    repeat (2) step();

    send4(4);
    repeat (2) step();
    send4(0);
    repeat (2) step();
    send4(7);
    repeat (3) step();
    send4(2);
    repeat (2) step();

    // G with start held and letter scrambled; D follows in the done cycle.
    start4  = 1'b1;
    letter4 = 3'd6;
    push_letter(4, 6, 4);
    guard = 0;
    while (q4.size() != 0 && guard < 500) begin
      step();
      letter4 = 3'($urandom_range(0, 7));
      guard++;
    end
    check("G drain", 8'(q4.size()), 8'd0);
    letter4 = 3'd3;
    push_letter(4, 3, 4);
    step();
    start4 = 1'b0;
    wait_idle(4);
    repeat (2) step();

    // Reset in the middle of B's leading dash.
    start4  = 1'b1;
    letter4 = 3'd1;
    push_letter(4, 1, 4);
    step();
    start4 = 1'b0;
    repeat (5) step();
    Reset = 1'b1;
    #1;
    check("async rst morse4", 8'(m4), 8'd0);
    check("async rst busy4",  8'(b4), 8'd0);
    check("async rst done4",  8'(d4), 8'd0);
    q4.delete();
    repeat (2) step();
    Reset = 1'b0;
    repeat (8) step();

    // TICK_DIV=1: F must read 1,0,1,0,1,1,1,0,1 then done.
    start1  = 1'b1;
    letter1 = 3'd5;
    push_letter(1, 5, 1);
    step();
    start1 = 1'b0;
    wait_idle(1);
    start1  = 1'b1;
    letter1 = 3'd6;
    push_letter(1, 6, 1);
    step();
    start1 = 1'b0;
    wait_idle(1);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/morse_letter_tx.md
# morse_letter_tx

Serial Morse transmitter for letters A–H. On a start request it latches a 3-bit letter code and plays the letter's dot/dash sequence on a single output line at a fixed unit rate, then signals completion. Its serial output is the symbol stream consumed by the downstream sequence-detector FSM (that FSM's `w` input) and by the board LED.

## Interface
- `TICK_DIV`, default 25_000_000: clock cycles per Morse time unit (0.5 s at 50 MHz); legal range 1 to 2^25.
- `Clock`  in  1  system clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-high; forces IDLE immediately.
- `start`  in  1  level-sampled request; honoured only in IDLE.
- `letter`  in  3  0=A … 7=H; sampled only on the edge that accepts `start`.
- `morse_out`  out  1  registered Morse line; 1 = tone/LED on.
- `busy`  out  1  registered; high whenever state ≠ IDLE.
- `done`  out  1  registered one-cycle pulse when a letter finishes.
- Reset values: `morse_out`=0, `busy`=0, `done`=0, state=IDLE, all counters 0.

## Operation
- Code table (1 = dash, sent MSB-first, length in symbols):
  - A .- (2), B -... (4), C -.-. (4), D -.. (3)
  - E . (1), F ..-. (4), G --. (3), H .... (4)
- Unit timing: dot = 1 unit on, dash = 3 units on, intra-letter gap = 1 unit off. No trailing gap after the last symbol.
- States: IDLE, MARK, SPACE.
  - IDLE: if `start`=1, load the 4-bit pattern left-aligned into the shift register, load the symbol count, clear the unit and prescaler counters, go to MARK with `morse_out`=1 and `busy`=1.
  - MARK: `morse_out`=1. Count units; on completion of 1 unit (dot) or 3 units (dash):
    - If symbols remain: go to SPACE and shift the pattern left.
    - Otherwise: go to IDLE with `morse_out`=0, `busy`=0, `done`=1.
  - SPACE: `morse_out`=0. After 1 unit, go to MARK with `morse_out`=1.
- `start` during MARK or SPACE is ignored; it is not queued, and `letter` changes are ignored.
- `start` may be accepted in the IDLE cycle where `done`=1. Back-to-back letters therefore have a 1-cycle low between them, not a unit gap; the spacing between letters is the requester's job.
- Prescaler counts 0…TICK_DIV−1. It wraps and issues a unit tick on reaching TICK_DIV−1. It is cleared on every state transition, so each phase is exactly N·TICK_DIV cycles.
- The prescaler is 25 bits, the unit counter 2 bits and the symbol counter 3 bits. No counter may overflow for any legal parameter value.
- Reset mid-letter: all outputs return to 0 asynchronously. After release, the block is in IDLE and waits for a fresh `start`.

## Timing
- If `start` is accepted at edge k, `morse_out` rises after edge k. Latency from start sample to line high is 0 cycles beyond the registering edge.
- The first symbol stays high for exactly TICK_DIV (dot) or 3·TICK_DIV (dash) cycles.
- Each SPACE lasts exactly TICK_DIV cycles.
- Total busy cycles for a letter = TICK_DIV · (Σ symbol units + symbols − 1).
- `done` is high for the single cycle following the final falling edge of `morse_out`. `busy` is low in that same cycle.
- With TICK_DIV=1, every phase lasts 1 cycle and the sequence must still be correct.

## Structure
- Package `morse_pkg` holds:
  - The state encoding constants (IDLE, MARK, SPACE).
  - Code-table constants, as a 3-bit index to {length[2:0], pattern[3:0]} function/ROM.
  - The unit-count constants DOT_UNITS=1, DASH_UNITS=3, GAP_UNITS=1.
- Sub-module `morse_unit_tick`:
  - Parameterised prescaler with inputs `Clock`, `Reset` and a synchronous `clear`.
  - Output `tick` is a one-cycle pulse every TICK_DIV cycles.
- The top level holds the FSM, the shift register and the unit and symbol counters.

## Test plan
All scenarios use TICK_DIV=4.
- Letter E (letter=4), start pulse 1 cycle → `morse_out` high 4 cycles, then `done`=1 for 1 cycle, `busy` high 4 cycles.
- Letter A (0) → line high 4, low 4, high 12, then `done`; busy total 20 cycles.
- Letter H (7) → four 4-cycle marks separated by 4-cycle spaces, 28 busy cycles. Then letter C (2) → 12/4/4/4/12/4/4 pattern, 44 cycles.
- Hold `start`=1 and toggle `letter` throughout a G (6) transmission → G sent unchanged (12/4/12/4/4). A new letter starts in the `done` cycle.
- Assert `Reset` mid-dash of letter B (1) → `morse_out`, `busy` and `done` go 0 immediately, before the next edge. After release with `start`=0, the line stays low.
- TICK_DIV=1, letter F (5) → `morse_out` sequence 1,0,1,0,1,1,1,0,1, then `done`.
